// File: rtl/core_pkg.sv
// Shared definitions for the five-stage MIPS core: exception codes and
// default values used by the pipeline stage registers.
package core_pkg;

  localparam logic [4:0] EXC_NONE    = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_REQ_PC = 32'h0000_4180;
  localparam int          DEF_TNEW_W = 2;

endpackage

// File: rtl/pipe_stage_reg_tnew_dec.sv
// Saturating decrement of a stage-relative T_new value: a result that is
// already available stays at zero instead of wrapping.
module tnew_dec #(
  parameter int TNEW_W = 2
) (
  input  logic [TNEW_W-1:0] tnew_i,
  output logic [TNEW_W-1:0] tnew_o
);

  assign tnew_o = (tnew_i == '0) ? '0 : tnew_i - TNEW_W'(1);

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: carries payload, PC, delay-slot flag,
// T_new and exception code, applying reset > Req > stall > bubble > load.
module pipe_stage_reg
  import core_pkg::*;
#(
  parameter int          PAYLOAD_W = 128,
  parameter int          TNEW_W    = core_pkg::DEF_TNEW_W,
  parameter int          EXC_W     = 5,
  parameter logic [31:0] REQ_PC    = core_pkg::DEF_REQ_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Req,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [31:0]          PC_in,
  input  logic                 BD_in,
  input  logic [TNEW_W-1:0]    T_new_in,
  input  logic [EXC_W-1:0]     ExcCode_in,
  input  logic [EXC_W-1:0]     ExcCode_stage,
  input  logic [PAYLOAD_W-1:0] payload_in,
  output logic                 valid_out,
  output logic [31:0]          PC_out,
  output logic                 BD_out,
  output logic [TNEW_W-1:0]    T_new_out,
  output logic [EXC_W-1:0]     ExcCode_out,
  output logic [PAYLOAD_W-1:0] payload_out,
  output logic                 exc_pending
);

  logic                 valid_q;
  logic [31:0]          pc_q;
  logic                 bd_q;
  logic [TNEW_W-1:0]    tnew_q;
  logic [EXC_W-1:0]     exc_q;
  logic [PAYLOAD_W-1:0] payload_q;

  logic [TNEW_W-1:0]    tnew_d;
  logic [EXC_W-1:0]     exc_d;

  tnew_dec #(.TNEW_W(TNEW_W)) u_tnew_dec (
    .tnew_i (T_new_in),
    .tnew_o (tnew_d)
  );

  // An exception from an earlier stage is older, so it beats one raised here.
  assign exc_d = (ExcCode_in != '0) ? ExcCode_in : ExcCode_stage;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      bd_q      <= 1'b0;
      tnew_q    <= '0;
      exc_q     <= '0;
      payload_q <= '0;
    end else if (Req) begin
      valid_q   <= 1'b0;
      pc_q      <= REQ_PC;
      bd_q      <= 1'b0;
      tnew_q    <= '0;
      exc_q     <= '0;
      payload_q <= '0;
    end else if (!stall) begin
      // Bubbles still carry PC/BD so EPC is right if an interrupt lands on one.
      if (flush || !valid_in) begin
        valid_q   <= 1'b0;
        pc_q      <= PC_in;
        bd_q      <= BD_in;
        tnew_q    <= '0;
        exc_q     <= '0;
        payload_q <= '0;
      end else begin
        valid_q   <= 1'b1;
        pc_q      <= PC_in;
        bd_q      <= BD_in;
        tnew_q    <= tnew_d;
        exc_q     <= exc_d;
        payload_q <= payload_in;
      end
    end
  end

  assign valid_out   = valid_q;
  assign PC_out      = pc_q;
  assign BD_out      = bd_q;
  assign T_new_out   = tnew_q;
  assign ExcCode_out = exc_q;
  assign payload_out = payload_q;
  assign exc_pending = valid_q & (exc_q != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipe_stage_reg;
  import core_pkg::*;

  typedef struct packed {
    logic         valid;
    logic [31:0]  pc;
    logic         bd;
    logic [1:0]   tnew;
    logic [4:0]   exc;
    logic [127:0] payload;
  } stage_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         Req = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [31:0]  PC_in = '0;
  logic         BD_in = 1'b0;
  logic [1:0]   T_new_in = '0;
  logic [4:0]   ExcCode_in = '0, ExcCode_stage = '0;
  logic [127:0] payload_in = '0;
  logic         valid_out, BD_out, exc_pending;
  logic [31:0]  PC_out;
  logic [1:0]   T_new_out;
  logic [4:0]   ExcCode_out;
  logic [127:0] payload_out;

  int     vectors = 0;
  int     miscompares = 0;
  logic   checkEn = 1'b0;
  stage_t model = '0;

  localparam logic [127:0] PAT_A5 = {4{32'hA5A5_A5A5}};

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .Req(Req), .stall(stall), .flush(flush),
    .valid_in(valid_in), .PC_in(PC_in), .BD_in(BD_in), .T_new_in(T_new_in),
    .ExcCode_in(ExcCode_in), .ExcCode_stage(ExcCode_stage),
    .payload_in(payload_in), .valid_out(valid_out), .PC_out(PC_out),
    .BD_out(BD_out), .T_new_out(T_new_out), .ExcCode_out(ExcCode_out),
    .payload_out(payload_out), .exc_pending(exc_pending)
  );

  always #5 clk = ~clk;

  // Reference: what one rising edge does to the stage, straight from the rules.
  function automatic stage_t modelNext(input stage_t cur);
    stage_t r;
    r = '0;
    if (Req) begin
      r.pc = 32'h0000_4180;
    end else if (stall) begin
      r = cur;
    end else if (flush || !valid_in) begin
      r.pc = PC_in;
      r.bd = BD_in;
    end else begin
      r.valid   = 1'b1;
      r.pc      = PC_in;
      r.bd      = BD_in;
      r.payload = payload_in;
      r.tnew    = (T_new_in == 2'd0) ? 2'd0 : T_new_in - 2'd1;
      r.exc     = (ExcCode_in != 5'd0) ? ExcCode_in : ExcCode_stage;
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model = '0;
    else        model = modelNext(model);
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model.valid",   valid_out,   model.valid);
      checkOutput("model.pc",      PC_out,      model.pc);
      checkOutput("model.bd",      BD_out,      model.bd);
      checkOutput("model.tnew",    T_new_out,   model.tnew);
      checkOutput("model.exc",     ExcCode_out, model.exc);
      checkOutput("model.payload", payload_out, model.payload);
      checkOutput("model.pending", exc_pending, model.valid && (model.exc != 5'd0));
    end
  end

  task automatic applyStimulus(input logic rq, input logic st, input logic fl, input logic vin,
                               input logic [31:0] pc, input logic bd, input logic [1:0] tn,
                               input logic [4:0] ei, input logic [4:0] es, input logic [127:0] pl);
    Req = rq; stall = st; flush = fl; valid_in = vin;
    PC_in = pc; BD_in = bd; T_new_in = tn;
    ExcCode_in = ei; ExcCode_stage = es; payload_in = pl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset.valid", valid_out, 0);
    checkOutput("reset.pc", PC_out, 0);
    checkOutput("reset.payload", payload_out, 0);
    reset = 1'b1;

    applyStimulus(0, 0, 0, 1, 32'h3004, 0, 2'd2, 5'd0, 5'd0, PAT_A5);
    checkOutput("load.tnew", T_new_out, 1);
    checkOutput("load.pc", PC_out, 32'h3004);
    checkOutput("load.valid", valid_out, 1);
    checkOutput("load.payload", payload_out, PAT_A5);

    applyStimulus(0, 0, 0, 1, 32'h3008, 0, 2'd0, 5'd0, 5'd0, PAT_A5);
    checkOutput("sat.tnew", T_new_out, 0);

    applyStimulus(0, 0, 1, 1, 32'h3010, 1, 2'd3, 5'd4, 5'd12, PAT_A5);
    checkOutput("flush.valid", valid_out, 0);
    checkOutput("flush.pc", PC_out, 32'h3010);
    checkOutput("flush.bd", BD_out, 1);
    checkOutput("flush.tnew", T_new_out, 0);
    checkOutput("flush.exc", ExcCode_out, 0);
    checkOutput("flush.payload", payload_out, 0);

    applyStimulus(0, 0, 0, 1, 32'h3020, 0, 2'd3, 5'd0, 5'd0, PAT_A5);
    applyStimulus(0, 0, 0, 0, 32'h3010, 1, 2'd3, 5'd0, 5'd10, PAT_A5);
    checkOutput("bubble.valid", valid_out, 0);
    checkOutput("bubble.pc", PC_out, 32'h3010);
    checkOutput("bubble.bd", BD_out, 1);
    checkOutput("bubble.exc", ExcCode_out, 0);
    checkOutput("bubble.payload", payload_out, 0);

    applyStimulus(0, 0, 0, 1, 32'h3030, 1, 2'd3, 5'd0, 5'd0, 128'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, (i == 1), 1'($urandom), $urandom, 1'($urandom), 2'($urandom),
                    5'($urandom), 5'($urandom), {4{$urandom}});
      checkOutput("stall.pc", PC_out, 32'h3030);
      checkOutput("stall.tnew", T_new_out, 2);
      checkOutput("stall.valid", valid_out, 1);
      checkOutput("stall.payload", payload_out, 128'h1234_5678);
    end

    applyStimulus(0, 0, 0, 1, 32'h3040, 0, 2'd1, EXC_NONE, EXC_OV, '0);
    checkOutput("exc.stage", ExcCode_out, 12);
    checkOutput("exc.pending", exc_pending, 1);
    applyStimulus(0, 0, 0, 1, 32'h3044, 0, 2'd1, EXC_ADEL, EXC_OV, '0);
    checkOutput("exc.earliest", ExcCode_out, 4);
    applyStimulus(0, 0, 0, 0, 32'h3048, 0, 2'd1, EXC_NONE, EXC_RI, '0);
    checkOutput("exc.bubble", ExcCode_out, 0);
    checkOutput("exc.bubblePending", exc_pending, 0);

    applyStimulus(0, 0, 0, 1, 32'h3050, 1, 2'd2, EXC_SYSCALL, EXC_NONE, PAT_A5);
    applyStimulus(1, 1, 1, 1, 32'h3054, 1, 2'd2, EXC_SYSCALL, EXC_NONE, PAT_A5);
    checkOutput("req.pc", PC_out, 32'h4180);
    checkOutput("req.valid", valid_out, 0);
    checkOutput("req.bd", BD_out, 0);
    checkOutput("req.tnew", T_new_out, 0);
    checkOutput("req.exc", ExcCode_out, 0);
    checkOutput("req.payload", payload_out, 0);
    checkOutput("req.pending", exc_pending, 0);

    applyStimulus(0, 0, 0, 1, 32'h3008, 1, 2'd2, 5'd0, 5'd0, PAT_A5);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checkOutput("areset.valid", valid_out, 0);
    checkOutput("areset.pc", PC_out, 0);
    checkOutput("areset.payload", payload_out, 0);
    @(negedge clk);
    checkOutput("areset.held", PC_out, 0);
    reset = 1'b1;
    #1 checkOutput("areset.release", PC_out, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("areset.reload", PC_out, 32'h3008);
    checkOutput("areset.reloadValid", valid_out, 1);

    // Random traffic, weighted so that loads dominate but every control shows up.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #2;
      reset         = ($urandom_range(0, 59) != 0);
      Req           = ($urandom_range(0, 15) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 5) == 0);
      valid_in      = ($urandom_range(0, 4) != 0);
      PC_in         = $urandom;
      BD_in         = 1'($urandom);
      T_new_in      = 2'($urandom);
      ExcCode_in    = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      ExcCode_stage = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      payload_in    = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline stage register for the five-stage MIPS core, replacing the per-stage hand-written D/E/M/W registers. It carries the stage payload, PC, branch-delay flag, stage-relative T_new and exception code, and applies the core's hold/bubble/exception-clear controls in a single fixed priority order. Unlike the earlier per-stage registers, it:
- keeps PC/BD through bubbles, so the macroscopic PC and EPC stay correct;
- merges in exceptions raised in the producing stage;
- tracks a valid bit.

## Interface
Parameters:
- PAYLOAD_W, 128, width of opaque control+data payload (RegWrite, MemtoReg, A3, ALU_C, HILO, DM_RD, CP0_RD, … packed by the instantiating stage)
- TNEW_W, 2, width of T_new
- EXC_W, 5, width of ExcCode
- REQ_PC, 32'h0000_4180, PC loaded on Req

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Req  in  1  exception/interrupt taken this cycle; clears stage
- stall  in  1  hold current contents
- flush  in  1  insert bubble
- valid_in  in  1  incoming instruction is real
- PC_in  in  32  instruction PC
- BD_in  in  1  instruction is in a delay slot
- T_new_in  in  TNEW_W  cycles until result ready, relative to producing stage
- ExcCode_in  in  EXC_W  exception carried from earlier stages (0 = none)
- ExcCode_stage  in  EXC_W  exception detected in producing stage (0 = none)
- payload_in  in  PAYLOAD_W  stage payload
- valid_out, PC_out, BD_out, T_new_out, ExcCode_out, payload_out  out  (matching widths)  registered copies
- exc_pending  out  1  combinational, valid_out & (ExcCode_out != 0)

## Operation
Actions, in priority order: highest first; exactly one applies per rising edge.
1. **reset = 0**: asynchronous. All outputs 0, including PC_out = 0 and valid_out = 0. Holds while low.
2. **Req**: valid_out = 0, PC_out = REQ_PC, and BD, T_new, ExcCode and payload all 0. Req overrides stall.
3. **stall**: every register holds, including T_new (no decrement). stall with flush → hold; flush is ignored.
4. **flush (bubble)**:
   - valid_out = 0; payload, T_new and ExcCode are 0.
   - PC_out = PC_in and BD_out = BD_in, retained so the macroscopic PC stays valid.
5. **load, valid_in = 1**:
   - PC, BD and payload copied.
   - T_new_out = T_new_in − 1, saturating at 0.
   - ExcCode_out = ExcCode_in if nonzero, else ExcCode_stage. The earliest exception wins.
6. **load, valid_in = 0**: treated as a bubble, identical to action 4; ExcCode_stage is ignored.

Other rules:
- ExcCode 0 means "no exception". Int is never carried per stage, because CP0 raises it.
- No wrap-around: the T_new decrement saturates.

## Timing
- Latency is 1 cycle for all captured fields. Outputs change only on a clk rising edge, except for asynchronous reset.
- Reset deassertion is synchronised externally; the first edge with reset = 1 performs normal priority evaluation.
- exc_pending is purely combinational from the registers; no extra latency.
- Reset mid-stall or mid-Req: reset wins immediately; no state survives.

## Structure
- Shared package core_pkg holds:
  - EXC_NONE = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_SYSCALL = 8, EXC_RI = 10, EXC_OV = 12
  - RESET_PC, REQ_PC default
  - TNEW_W default
- Sub-module tnew_dec: saturating decrement of T_new, parametrised by TNEW_W.
- Everything else lives in one always block with an asynchronous-reset sensitivity.

## Test plan
- **Async reset:** reset driven low between edges while loaded (PC_out 0x3008, valid 1) → all outputs 0 before the next edge; they stay 0 until reset = 1 plus one load.
- **Load / T_new saturation:**
  - Load valid, PC 0x3004, T_new_in 2, payload 0xA5… → next edge T_new_out 1, PC_out 0x3004, valid 1.
  - Load T_new_in 0 → T_new_out 0.
- **Bubble keeps PC/BD:** flush = 1, PC_in 0x3010, BD_in 1 → valid_out 0, payload 0, T_new 0, ExcCode 0, PC_out 0x3010, BD_out 1. Repeat with valid_in = 0 and no flush → same result.
- **Stall hold:**
  - stall = 1 for 3 cycles with inputs changing → outputs identical every cycle, T_new not decremented.
  - stall + flush together → hold.
- **Exception merge:**
  - ExcCode_in 0, stage 12 → out 12, exc_pending 1.
  - in 4, stage 12 → out 4.
  - valid_in 0, stage 10 → out 0.
- **Req priority:** Req with stall = 1 and flush = 1, valid loaded → PC_out 0x4180; valid, BD, T_new, ExcCode and payload all 0; exc_pending 0.
